rate_limiter_channel_sequencer: RTL

- Time-shares one rate-limiter datapath between NUM_CH receiver channels: throttle, yaw, roll and pitch by default.
- One frame starts on each start_signal pulse from the receiver side. The block snapshots all channel inputs and feeds them one at a time, round-robin from channel 0, into the limiter using its start/active/complete handshake.
- Each limited result is stored in a per-channel output register. complete_signal pulses once when the whole frame is done.
- Sits between the receiver module and the motor mixer, in the us_clk domain.

---
 rtl/rate_limiter_channel_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rate_limiter_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rate_limiter_channel_sequencer
// Purpose  : Time-shares one rate-limiter datapath between NUM_CH receiver
//            channels. On each start_signal pulse the block snapshots every
//            channel input and presents the values one at a time,
//            round-robin from channel 0, to the limiter through its
//            start/complete handshake. Each limited result lands in a
//            per-channel output register. complete_signal pulses once at the
//            end of the frame.
// Macro    : SEQ_BYPASS_ON_TIMEOUT_EN - when defined, a channel that times
//            out is written with its raw snapshot value (zero-extended)
//            instead of keeping its previous result.
// Ports    : us_clk            block clock (rising edge)
//            resetn            synchronous active-low reset
//            start_signal      frame request, sampled only when idle
//            ch_values_in      packed channel inputs, ch k at [k*IN_W +: IN_W]
//            ch_values_out     packed limited results, same packing
//            limiter_value_in  value presented to the limiter
//            limiter_start     start strobe to the limiter
//            limiter_active    limiter busy status (checked, not used)
//            limiter_complete  limiter result-valid
//            limiter_value_out limiter result
//            ch_sel            channel currently being serviced
//            active_signal     high whenever a frame is in progress
//            complete_signal   one-cycle end-of-frame pulse
//            timeout_error     sticky channel-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module rate_limiter_channel_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int IN_W        = 8,
    parameter int OUT_W       = 16,
    parameter int START_HOLD  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    us_clk,
    input  logic                    resetn,
    input  logic                    start_signal,
    input  logic [NUM_CH*IN_W-1:0]  ch_values_in,
    output logic [NUM_CH*OUT_W-1:0] ch_values_out,
    output logic [IN_W-1:0]         limiter_value_in,
    output logic                    limiter_start,
    input  logic                    limiter_active,
    input  logic                    limiter_complete,
    input  logic [OUT_W-1:0]        limiter_value_out,
    output logic [2:0]              ch_sel,
    output logic                    active_signal,
    output logic                    complete_signal,
    output logic                    timeout_error
);

    localparam int              CH_W        = $clog2(NUM_CH);
    localparam int              TMO_W       = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      C_HOLD_LAST = 4'(START_HOLD - 1);
    localparam logic [2:0]      C_CH_LAST   = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                        r_state;
    logic [NUM_CH-1:0][IN_W-1:0]   r_snap;
    logic [NUM_CH-1:0][OUT_W-1:0]  r_out;
    logic [3:0]                    r_hold;
    logic [TMO_W-1:0]              r_tmo;
    logic [OUT_W-1:0]              r_result;
    logic                          r_wr_en;
    logic [2:0]                    r_ch_sel;
    logic [IN_W-1:0]               r_lim_val;
    logic                          r_lim_start;
    logic                          r_active;
    logic                          r_complete;
    logic                          r_timeout;

    logic [CH_W-1:0]               w_idx;
    logic [CH_W-1:0]               w_next_idx;

    // ch_sel never exceeds NUM_CH-1, so only its low CH_W bits address slots
    assign w_idx      = r_ch_sel[CH_W-1:0];
    assign w_next_idx = w_idx + CH_W'(1);

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_snap      <= '0;
            r_out       <= '0;
            r_hold      <= '0;
            r_tmo       <= '0;
            r_result    <= '0;
            r_wr_en     <= 1'b0;
            r_ch_sel    <= '0;
            r_lim_val   <= '0;
            r_lim_start <= 1'b0;
            r_active    <= 1'b0;
            r_complete  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_signal) begin
                        r_snap      <= ch_values_in;
                        r_ch_sel    <= '0;
                        // channel 0 comes straight from the input: the
                        // snapshot is being written on this same edge
                        r_lim_val   <= ch_values_in[IN_W-1:0];
                        r_lim_start <= 1'b1;
                        r_hold      <= '0;
                        r_active    <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (r_hold == C_HOLD_LAST) begin
                        r_lim_start <= 1'b0;
                        r_tmo       <= '0;
                        r_state     <= S_WAIT;
                    end else begin
                        r_hold <= r_hold + 4'd1;
                    end
                end

                S_WAIT: begin
                    // a result arriving on the last allowed cycle wins
                    // over the timeout
                    if (limiter_complete) begin
                        r_result <= limiter_value_out;
                        r_wr_en  <= 1'b1;
                        r_state  <= S_STORE;
                    end else if (r_tmo == C_TMO_LAST) begin
                        r_timeout <= 1'b1;
`ifdef SEQ_BYPASS_ON_TIMEOUT_EN
                        r_result  <= OUT_W'(r_snap[w_idx]);
                        r_wr_en   <= 1'b1;
`else
                        r_wr_en   <= 1'b0;
`endif
                        r_state   <= S_STORE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                S_STORE: begin
                    if (r_wr_en) begin
                        r_out[w_idx] <= r_result;
                    end
                    if (r_ch_sel == C_CH_LAST) begin
                        r_complete <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_ch_sel    <= r_ch_sel + 3'd1;
                        r_lim_val   <= r_snap[w_next_idx];
                        r_lim_start <= 1'b1;
                        r_hold      <= '0;
                        r_state     <= S_ISSUE;
                    end
                end

                S_DONE: begin
                    r_complete <= 1'b0;
                    r_active   <= 1'b0;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ch_values_out    = r_out;
    assign limiter_value_in = r_lim_val;
    assign limiter_start    = r_lim_start;
    assign ch_sel           = r_ch_sel;
    assign active_signal    = r_active;
    assign complete_signal  = r_complete;
    assign timeout_error    = r_timeout;

`ifndef SYNTHESIS
    // The limiter must report busy for as long as a result is pending.
    always_ff @(posedge us_clk) begin
        if (resetn && (r_state == S_WAIT) && !limiter_complete) begin
            assert (limiter_active)
                else $error("limiter_active low while awaiting a result");
        end
    end
`endif

endmodule
`default_nettype wire
